// File: rtl/multirate_v2_mul_arbiter_if.sv
// Request/response bundle for the round-robin multiplier arbiter.
// Valid/ready: a transfer happens on a rising edge where valid and ready are both high; ready may depend on valid, never the reverse.
interface multirate_v2_mul_arbiter_if #(
   parameter int NUM_REQ    = 4,
   parameter int DIN0_WIDTH = 16,
   parameter int DIN1_WIDTH = 10,
   parameter int DOUT_WIDTH = 26,
   parameter int ID_WIDTH   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
);
   logic [NUM_REQ-1:0]            req_valid;
   logic [NUM_REQ-1:0]            req_ready;
   logic [NUM_REQ*DIN0_WIDTH-1:0] req_din0;
   logic [NUM_REQ*DIN1_WIDTH-1:0] req_din1;
   logic                          resp_valid;
   logic                          resp_ready;
   logic [DOUT_WIDTH-1:0]         resp_dout;
   logic [ID_WIDTH-1:0]           resp_id;
   logic                          busy;

   modport slave (
      input  req_valid, req_din0, req_din1, resp_ready,
      output req_ready, resp_valid, resp_dout, resp_id, busy
   );

   modport master (
      output req_valid, req_din0, req_din1, resp_ready,
      input  req_ready, resp_valid, resp_dout, resp_id, busy
   );
endinterface

// File: rtl/multirate_v2_mul_arbiter.sv
// Round-robin arbiter feeding a shared signed multiplier with a MUL_STAGES-deep
// output pipeline; the whole pipeline freezes while the head product is refused.
module multirate_v2_mul_arbiter #(
   parameter int NUM_REQ    = 4,
   parameter int DIN0_WIDTH = 16,
   parameter int DIN1_WIDTH = 10,
   parameter int DOUT_WIDTH = 26,
   parameter int MUL_STAGES = 1
) (
   input logic                       ap_clk,
   input logic                       ap_rst,
   multirate_v2_mul_arbiter_if.slave bus
);
   localparam int ID_WIDTH   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int PROD_WIDTH = DIN0_WIDTH + DIN1_WIDTH;

   logic [ID_WIDTH-1:0]          ptr_q, ptr_d;
   logic [MUL_STAGES-1:0]        vld_q;
   logic [DOUT_WIDTH-1:0]        prod_q [MUL_STAGES];
   logic [ID_WIDTH-1:0]          id_q   [MUL_STAGES];

   logic                         stall;
   logic                         found;
   logic                         accept;
   logic [ID_WIDTH-1:0]          cand;
   logic [ID_WIDTH-1:0]          gnt_idx;
   logic [NUM_REQ-1:0]           gnt;
   logic [DIN0_WIDTH-1:0]        din0_arr [NUM_REQ];
   logic [DIN1_WIDTH-1:0]        din1_arr [NUM_REQ];
   logic signed [DIN0_WIDTH-1:0] op0;
   logic signed [DIN1_WIDTH-1:0] op1;
   logic signed [PROD_WIDTH-1:0] prod_full;
   logic [DOUT_WIDTH-1:0]        prod_ext;

   for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
      assign din0_arr[i] = bus.req_din0[i*DIN0_WIDTH +: DIN0_WIDTH];
      assign din1_arr[i] = bus.req_din1[i*DIN1_WIDTH +: DIN1_WIDTH];
   end

   assign stall = vld_q[MUL_STAGES-1] & ~bus.resp_ready;

   // First valid requester strictly after the pointer, wrapping modulo NUM_REQ.
   always_comb begin
      found   = 1'b0;
      cand    = '0;
      gnt_idx = '0;
      gnt     = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         cand = ID_WIDTH'((int'(ptr_q) + k) % NUM_REQ);
         if (!found && bus.req_valid[cand]) begin
            found   = 1'b1;
            gnt_idx = cand;
         end
      end
      if (found && !stall && !ap_rst) gnt[gnt_idx] = 1'b1;
   end

   assign accept    = |gnt;
   assign ptr_d     = accept ? gnt_idx : ptr_q;
   assign op0       = din0_arr[gnt_idx];
   assign op1       = din1_arr[gnt_idx];
   assign prod_full = op0 * op1;
   assign prod_ext  = DOUT_WIDTH'(prod_full);

   always_ff @(posedge ap_clk) begin
      if (ap_rst) begin
         ptr_q <= ID_WIDTH'(NUM_REQ - 1);
         vld_q <= '0;
         for (int s = 0; s < MUL_STAGES; s++) begin
            prod_q[s] <= '0;
            id_q[s]   <= '0;
         end
      end else begin
         ptr_q <= ptr_d;
         if (!stall) begin
            vld_q[0] <= accept;
            if (accept) begin
               prod_q[0] <= prod_ext;
               id_q[0]   <= gnt_idx;
            end
            for (int s = 1; s < MUL_STAGES; s++) begin
               vld_q[s]  <= vld_q[s-1];
               prod_q[s] <= prod_q[s-1];
               id_q[s]   <= id_q[s-1];
            end
         end
      end
   end

   assign bus.req_ready  = gnt;
   assign bus.resp_valid = vld_q[MUL_STAGES-1];
   assign bus.resp_dout  = prod_q[MUL_STAGES-1];
   assign bus.resp_id    = id_q[MUL_STAGES-1];
   assign bus.busy       = |vld_q;
endmodule

// File: tb/tb_multirate_v2_mul_arbiter.sv
// Bench for multirate_v2_mul_arbiter: two instances (1 and 3 product stages) share stimulus,
// each with its own reference model and response scoreboard.
module tb_multirate_v2_mul_arbiter;
   localparam int NR  = 4;
   localparam int D0W = 16;
   localparam int D1W = 10;
   localparam int DW  = 26;
   localparam int IW  = 2;

   logic clk = 1'b0;
   logic rst;
   logic [NR-1:0]     req_valid;
   logic [NR*D0W-1:0] req_din0;
   logic [NR*D1W-1:0] req_din1;
   logic              resp_ready;

   logic [NR-1:0] o_ready [2];
   logic          o_valid [2];
   logic          o_busy  [2];
   logic [DW-1:0] o_dout  [2];
   logic [IW-1:0] o_id    [2];
   int            acc_cnt [2];

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   for (genvar g = 0; g < 2; g++) begin : cfg
      localparam int MS = (g == 0) ? 1 : 3;

      multirate_v2_mul_arbiter_if #(.NUM_REQ(NR), .DIN0_WIDTH(D0W), .DIN1_WIDTH(D1W),
                                    .DOUT_WIDTH(DW)) bus ();

      multirate_v2_mul_arbiter #(.NUM_REQ(NR), .DIN0_WIDTH(D0W), .DIN1_WIDTH(D1W),
                                 .DOUT_WIDTH(DW), .MUL_STAGES(MS)) dut (
         .ap_clk (clk),
         .ap_rst (rst),
         .bus    (bus)
      );

      assign bus.req_valid  = req_valid;
      assign bus.req_din0   = req_din0;
      assign bus.req_din1   = req_din1;
      assign bus.resp_ready = resp_ready;
      assign o_ready[g]     = bus.req_ready;
      assign o_valid[g]     = bus.resp_valid;
      assign o_busy[g]      = bus.busy;
      assign o_dout[g]      = bus.resp_dout;
      assign o_id[g]        = bus.resp_id;

      // Scoreboard: expected products in acceptance order, each with the number of
      // unstalled edges it has seen since acceptance.
      logic [DW-1:0] exp_q [$];
      int            id_q  [$];
      int            age_q [$];
      int            ptr_m = NR - 1;
      bit            stall_m = 1'b0;

      always @(negedge clk) begin : monitor
         bit vis;
         vis = (age_q.size() > 0) && (age_q[0] >= MS - 1);
         if (rst) begin
            stall_m = 1'b0;
         end else begin
            chk($sformatf("cfg%0d resp_valid", g), o_valid[g], vis);
            chk($sformatf("cfg%0d busy", g), o_busy[g], exp_q.size() > 0);
            stall_m = vis && !resp_ready;
            if (vis && resp_ready) begin
               chk($sformatf("cfg%0d resp_dout", g), $signed(o_dout[g]), $signed(exp_q[0]));
               chk($sformatf("cfg%0d resp_id", g), o_id[g], id_q[0]);
               void'(exp_q.pop_front());
               void'(id_q.pop_front());
               void'(age_q.pop_front());
            end
         end
      end

      always @(negedge clk) begin : model
         logic [NR-1:0] exp_rdy;
         int            gi;
         int            c;
         longint        p;
         #1;
         exp_rdy = '0;
         gi      = -1;
         if (!rst && !stall_m) begin
            for (int k = 1; k <= NR; k++) begin
               c = (ptr_m + k) % NR;
               if (gi < 0 && req_valid[c]) gi = c;
            end
         end
         if (gi >= 0) exp_rdy[gi] = 1'b1;
         chk($sformatf("cfg%0d req_ready", g), o_ready[g], exp_rdy);
         if (rst) begin
            exp_q.delete();
            id_q.delete();
            age_q.delete();
            ptr_m = NR - 1;
         end else begin
            if (!stall_m) foreach (age_q[i]) age_q[i]++;
            if (gi >= 0) begin
               p = longint'($signed(req_din0[gi*D0W +: D0W])) * longint'($signed(req_din1[gi*D1W +: D1W]));
               exp_q.push_back(DW'(p));
               id_q.push_back(gi);
               age_q.push_back(0);
               ptr_m = gi;
               acc_cnt[g]++;
            end
         end
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic set_lane(input int i, input int a, input int b);
      req_din0[i*D0W +: D0W] = D0W'(a);
      req_din1[i*D1W +: D1W] = D1W'(b);
   endtask

   task automatic do_reset();
      rst       = 1'b1;
      req_valid = '0;
      cyc();
      rst = 1'b0;
   endtask

   function automatic int rnd_op(input int w);
      case ($urandom_range(0, 7))
         0:       return -(1 << (w - 1));
         1:       return (1 << (w - 1)) - 1;
         2:       return -1;
         default: return int'($urandom_range(0, (1 << w) - 1));
      endcase
   endfunction

   initial begin : timeout
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      n_fail++;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $fatal(1, "watchdog");
   end

   initial begin : stim
      int fair [6] = '{0, 1, 2, 3, 0, 1};
      int n_cyc;
      int start;
      rst        = 1'b1;
      req_valid  = '0;
      req_din0   = '0;
      req_din1   = '0;
      resp_ready = 1'b1;
      acc_cnt[0] = 0;
      acc_cnt[1] = 0;
      cyc();
      cyc();
      rst = 1'b0;

      @(negedge clk);
      for (int g = 0; g < 2; g++) begin
         chk("reset resp_valid", o_valid[g], 0);
         chk("reset busy", o_busy[g], 0);
         chk("reset resp_dout", o_dout[g], 0);
         chk("reset resp_id", o_id[g], 0);
      end
      cyc();

      // Lone requester 2 with both operands at their most negative value.
      set_lane(2, -32768, -512);
      req_valid = 4'b0100;
      @(negedge clk);
      chk("single grant", o_ready[0], 4'b0100);
      cyc();
      req_valid = '0;
      @(negedge clk);
      chk("single resp_valid", o_valid[0], 1);
      chk("single resp_id", o_id[0], 2);
      chk("single resp_dout", o_dout[0], 64'h1000000);
      cyc();

      // All requesters valid: strict rotation starting at requester 0.
      do_reset();
      for (int i = 0; i < NR; i++) set_lane(i, i + 1, -(i + 2));
      req_valid = 4'b1111;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         chk($sformatf("fair grant %0d", k), o_ready[0], 1 << fair[k]);
         chk($sformatf("fair resp_valid %0d", k), o_valid[0], k > 0);
         cyc();
      end
      req_valid = '0;
      cyc();

      // Back-to-back transfers with a four-cycle refusal after the first product.
      do_reset();
      set_lane(0, 100, 3);
      req_valid = 4'b0001;
      @(negedge clk);
      chk("bp grant 1", o_ready[0], 4'b0001);
      cyc();
      set_lane(0, -7, 511);
      resp_ready = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk("bp stall resp_valid", o_valid[0], 1);
         chk("bp stall resp_dout", $signed(o_dout[0]), 300);
         chk("bp stall req_ready", o_ready[0], 0);
         cyc();
      end
      resp_ready = 1'b1;
      @(negedge clk);
      chk("bp resp 1", $signed(o_dout[0]), 300);
      chk("bp grant 2", o_ready[0], 4'b0001);
      cyc();
      set_lane(0, 32767, -1);
      @(negedge clk);
      chk("bp resp 2", $signed(o_dout[0]), -3577);
      chk("bp grant 3", o_ready[0], 4'b0001);
      cyc();
      req_valid = '0;
      @(negedge clk);
      chk("bp resp 3", $signed(o_dout[0]), -32767);
      cyc();
      @(negedge clk);
      chk("bp drained", o_valid[0], 0);
      cyc();

      // Pointer parked at 3: requester 0 wins before requester 3.
      do_reset();
      set_lane(0, 5, 6);
      set_lane(3, -9, 8);
      req_valid = 4'b1001;
      @(negedge clk);
      chk("wrap first", o_ready[0], 4'b0001);
      cyc();
      @(negedge clk);
      chk("wrap second", o_ready[0], 4'b1000);
      cyc();
      req_valid = '0;
      repeat (4) cyc();

      // Reset while two products are inside the three-stage instance.
      do_reset();
      req_valid = 4'b0011;
      cyc();
      cyc();
      req_valid = 4'b1111;
      rst = 1'b1;
      @(negedge clk);
      chk("rst req_ready cfg0", o_ready[0], 0);
      chk("rst req_ready cfg1", o_ready[1], 0);
      cyc();
      rst = 1'b0;
      req_valid = '0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk("post-rst resp_valid", o_valid[1], 0);
         chk("post-rst busy", o_busy[1], 0);
         cyc();
      end
      req_valid = 4'b1111;
      @(negedge clk);
      chk("post-rst grant", o_ready[1], 4'b0001);
      cyc();
      req_valid = '0;
      repeat (5) cyc();

      // Random traffic and random downstream backpressure.
      n_cyc = 0;
      start = acc_cnt[0];
      while (acc_cnt[0] - start < 10000 && n_cyc < 40000) begin
         rst       = ($urandom_range(0, 1999) == 0);
         req_valid = NR'($urandom_range(0, (1 << NR) - 1));
         for (int i = 0; i < NR; i++) set_lane(i, rnd_op(D0W), rnd_op(D1W));
         resp_ready = ($urandom_range(0, 3) != 0);
         cyc();
         n_cyc++;
      end
      rst = 1'b0;
      chk("random transfer count reached", acc_cnt[0] - start >= 10000, 1);
      req_valid  = '0;
      resp_ready = 1'b1;
      repeat (10) cyc();
      @(negedge clk);
      chk("final busy cfg0", o_busy[0], 0);
      chk("final busy cfg1", o_busy[1], 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/multirate_v2_mul_arbiter.md
MULTIRATE_V2_MUL_ARBITER -- requirements
Module: multirate_v2_mul_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requesters (2..8).
REQ-002 SHALL have parameter DIN0_WIDTH, default 16, signed sample operand width.
REQ-003 SHALL have parameter DIN1_WIDTH, default 10, signed coefficient operand width.
REQ-004 SHALL have parameter DOUT_WIDTH, default 26, product width.
REQ-005 SHALL have parameter MUL_STAGES, default 1, registered pipeline stages after the multiply (1..3).
REQ-006 SHALL have port ap_clk  input  1  single clock; all logic on its rising edge.
REQ-007 SHALL have port ap_rst  input  1  synchronous, active-high reset.
REQ-008 SHALL have port req_valid  input  NUM_REQ  per-requester operand valid.
REQ-009 SHALL have port req_ready  output  NUM_REQ  per-requester grant/accept.
REQ-010 SHALL have port req_din0  input  NUM_REQ*DIN0_WIDTH  packed operands; requester i at bits [i*DIN0_WIDTH +: DIN0_WIDTH].
REQ-011 SHALL have port req_din1  input  NUM_REQ*DIN1_WIDTH  packed operands, same packing rule.
REQ-012 SHALL have port resp_valid  output  1  product valid.
REQ-013 SHALL have port resp_ready  input  1  downstream accepts product.
REQ-014 SHALL have port resp_dout  output  DOUT_WIDTH  signed product.
REQ-015 SHALL have port resp_id  output  clog2(NUM_REQ)  index of requester owning resp_dout.
REQ-016 SHALL have port busy  output  1  high while any pipeline stage holds a valid entry.

Function
REQ-017 SHALL define stall = resp_valid AND NOT resp_ready; while stall, all pipeline stages, resp_* and the RR pointer hold.
REQ-018 SHALL, when not stalled, grant exactly one valid requester per cycle by round-robin, searching from pointer+1 upward with wrap-around modulo NUM_REQ.
REQ-019 SHALL drive req_ready[i] combinationally high only for the granted requester; all req_ready low when stalled or no req_valid.
REQ-020 SHALL accept a transfer when req_valid[i] AND req_ready[i] at a rising edge, and then update the pointer to i.
REQ-021 SHALL leave the pointer unchanged in cycles with no accepted transfer.
REQ-022 SHALL compute the full-precision signed product din0*din1, sign-extended to DOUT_WIDTH; no rounding, saturation or truncation.
REQ-023 SHALL register product, id and valid MUL_STAGES times; a transfer accepted at edge k appears on resp_* after edge k+MUL_STAGES-1, i.e. latency MUL_STAGES cycles, when unstalled.
REQ-024 SHALL sustain one accepted transfer per cycle while resp_ready is high.
REQ-025 SHALL preserve acceptance order on the response side; no entry dropped or duplicated under any resp_ready pattern.
REQ-026 SHALL hold resp_dout and resp_id stable while resp_valid is high and resp_ready is low.
REQ-027 SHALL allow an empty (bubble) stage to advance even while stalled only if it does not overwrite a valid entry; the default implementation holds the whole pipeline on stall, which is acceptable.
REQ-028 SHALL drive busy = OR of all stage valid bits.

Reset
REQ-029 SHALL, on ap_rst high at a rising edge, clear all stage valids, resp_valid=0, resp_dout=0, resp_id=0, busy=0, and set the pointer to NUM_REQ-1 so requester 0 has first priority.
REQ-030 SHALL, on reset mid-operation, discard all in-flight products; no response for them appears after reset.
REQ-031 SHALL hold req_ready all low during any cycle in which ap_rst is high.

Verification
REQ-032 SHALL cover single request: only req 2 valid, din0=-32768, din1=-512 -> one cycle later resp_valid=1, resp_id=2, resp_dout=0x1000000.
REQ-033 SHALL cover fairness: all 4 requesters valid continuously after reset -> grants in order 0,1,2,3,0,1 over 6 consecutive cycles, one response per cycle.
REQ-034 SHALL cover backpressure: 3 back-to-back transfers of 100*3, -7*511, 32767*-1, with resp_ready low for 4 cycles after the first response -> responses 300, -3577, -32767 in order; resp_dout stable during the stall; req_ready low during the stall.
REQ-035 SHALL cover wrap-around: pointer at 3 with req 0 and req 3 valid -> req 0 granted first, then req 3.
REQ-036 SHALL cover reset mid-flight: MUL_STAGES=3, two transfers accepted, ap_rst high 1 cycle -> no resp_valid afterwards, busy=0, next grant goes to requester 0.
REQ-037 SHALL cover a random-stimulus scoreboard run (>=10000 transfers, random valid/ready) checking products, ids and per-requester ordering.
